// File: rtl/axis_router_pkg.sv
// Shared types and sizing helpers for the AXI-stream packet router blocks.
package axis_router_pkg;

   typedef enum logic [1:0] {
      HEAD,
      BODY,
      DROP
   } demux_state_t;

   localparam int DROP_CNT_W = 16;

   // Index width for a port count; a lone port still needs one bit.
   function automatic int port_idx_w(input int num_ports);
      return (num_ports < 2) ? 1 : $clog2(num_ports);
   endfunction

endpackage

// File: rtl/axis_packet_demux.sv
// Steers each AXI-stream packet to the master port named in its header beat; out-of-range packets are dropped.
// Optional AXIS_DEMUX_DROP_COUNT_EN adds a saturating 16-bit dropped-packet counter on port drop_count.
module axis_packet_demux
   import axis_router_pkg::*;
#(
   parameter int TDATA_WIDTH = 32,
   parameter int NUM_PORTS   = 4,
   parameter int DEST_LSB    = 0,
   parameter int DEST_WIDTH  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                   s_axis_tlast,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tlast,
   output logic [NUM_PORTS-1:0]   m_axis_tvalid,
   input  logic [NUM_PORTS-1:0]   m_axis_tready
`ifdef AXIS_DEMUX_DROP_COUNT_EN
   ,output logic [DROP_CNT_W-1:0] drop_count
`endif
);

   localparam int PORT_IDX_W = port_idx_w(NUM_PORTS);

   demux_state_t r_state, w_state_next;

   logic [PORT_IDX_W-1:0]  r_out_port, r_cur_port, w_load_port, w_dest_port;
   logic [NUM_PORTS-1:0]   r_valid, w_onehot;
   logic [TDATA_WIDTH-1:0] r_tdata;
   logic                   r_tlast;
   logic [DEST_WIDTH-1:0]  w_dest;
   logic                   w_dest_ok, w_out_free, w_rdy, w_accept, w_load;

   assign w_dest      = s_axis_tdata[DEST_LSB +: DEST_WIDTH];
   assign w_dest_ok   = (32'(w_dest) < NUM_PORTS);
   assign w_dest_port = PORT_IDX_W'(w_dest);

   // The output register is free when empty or when its current beat drains this cycle.
   assign w_out_free    = ~(|r_valid) | m_axis_tready[r_out_port];
   assign w_rdy         = (r_state == DROP) | w_out_free;
   assign s_axis_tready = ~reset & w_rdy;
   assign w_accept      = s_axis_tvalid & s_axis_tready;

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
         assign w_onehot[gi] = (w_load_port == PORT_IDX_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= HEAD;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_load_port  = r_cur_port;
      case (r_state)
         HEAD: begin
            if (w_accept) begin
               if (w_dest_ok) begin
                  w_load      = 1'b1;
                  w_load_port = w_dest_port;
                  if (!s_axis_tlast) w_state_next = BODY;
               end else if (!s_axis_tlast) begin
                  w_state_next = DROP;
               end
            end
         end
         BODY: begin
            if (w_accept) begin
               w_load = 1'b1;
               if (s_axis_tlast) w_state_next = HEAD;
            end
         end
         DROP: begin
            if (w_accept && s_axis_tlast) w_state_next = HEAD;
         end
         default: w_state_next = HEAD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid    <= '0;
         r_out_port <= '0;
         r_cur_port <= '0;
      end else if (w_load) begin
         r_valid    <= w_onehot;
         r_out_port <= w_load_port;
         r_cur_port <= w_load_port;
      end else if (w_out_free) begin
         r_valid <= '0;
      end
   end

   // Payload carries no reset: it is only observed qualified by r_valid.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_tdata <= s_axis_tdata;
         r_tlast <= s_axis_tlast;
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tvalid = r_valid;

`ifdef AXIS_DEMUX_DROP_COUNT_EN
   logic [DROP_CNT_W-1:0] r_drop_count;
   logic                  w_drop_hdr;

   assign w_drop_hdr = w_accept & (r_state == HEAD) & ~w_dest_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                  r_drop_count <= '0;
      else if (w_drop_hdr && r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
   end

   assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_axis_packet_demux.sv
// Directed and randomized checks of axis_packet_demux against a per-port expected-beat queue model.
module tb_axis_packet_demux;

   localparam int NP = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tlast;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tlast;
   logic [3:0]  m_axis_tvalid;
   logic [3:0]  m_axis_tready;
`ifdef AXIS_DEMUX_DROP_COUNT_EN
   logic [15:0] drop_count;
`endif

   axis_packet_demux #(
      .TDATA_WIDTH(32), .NUM_PORTS(NP), .DEST_LSB(0), .DEST_WIDTH(4)
   ) dut (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
`ifdef AXIS_DEMUX_DROP_COUNT_EN
      , .drop_count(drop_count)
`endif
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [32:0] exp_q [NP][$];   // {tlast, tdata} per port, in delivery order
   int          exp_drops;
   bit          rand_ready;
   logic [3:0]  force_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Port-side ready: either forced or about 75% random per port, changed just after each edge.
   always @(posedge clk) begin
      #1;
      if (rand_ready) m_axis_tready = 4'($urandom) | 4'($urandom);
      else            m_axis_tready = force_ready;
   end

   // Output monitor: every completed handshake must match the next expected beat for that port.
   logic [3:0]  prev_valid;
   logic [31:0] prev_data;
   bit          prev_hold;
   logic [32:0] mon_e;
   always @(negedge clk) begin
      if (reset) begin
         prev_hold = 1'b0;
      end else begin
         chk("onehot0", 32'($onehot0(m_axis_tvalid)), 32'd1);
         if (prev_hold) begin
            chk("hold_valid", 32'(m_axis_tvalid), 32'(prev_valid));
            chk("hold_data", m_axis_tdata, prev_data);
         end
         prev_hold = 1'b0;
         for (int p = 0; p < NP; p++) begin
            if (m_axis_tvalid[p]) begin
               if (m_axis_tready[p]) begin
                  chk("out_expected", 32'(exp_q[p].size() > 0), 32'd1);
                  if (exp_q[p].size() > 0) begin
                     mon_e = exp_q[p].pop_front();
                     chk("out_data", m_axis_tdata, mon_e[31:0]);
                     chk("out_last", 32'(m_axis_tlast), 32'(mon_e[32]));
                  end
               end else begin
                  prev_hold = 1'b1;
               end
            end
         end
         prev_valid = m_axis_tvalid;
         prev_data  = m_axis_tdata;
      end
   end

   // Waits for the presented beat to be accepted, records it in the model, then drops tvalid.
   task automatic wait_accept(input int dest, input bit hdr, output int waits);
      bit got = 1'b0;
      waits = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (s_axis_tvalid && s_axis_tready) begin
            got = 1'b1;
            break;
         end
         waits++;
      end
      chk("accept_timeout", 32'(got), 32'd1);
      if (got) begin
         if (dest < NP)                   exp_q[dest].push_back({s_axis_tlast, s_axis_tdata});
         else if (hdr && exp_drops < 65535) exp_drops++;
      end
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic put(input logic [31:0] d, input logic l, input int dest, input bit hdr, output int waits);
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      wait_accept(dest, hdr, waits);
   endtask

   task automatic send_packet(input int dest, input int len, input bit gaps);
      logic [31:0] r;
      int w;
      for (int i = 0; i < len; i++) begin
         r = $urandom;
         if (i == 0) r = {r[31:4], 4'(dest)};
         put(r, (i == len - 1), dest, (i == 0), w);
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      int w;
      int total;
      reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
      rand_ready = 1'b0; force_ready = 4'hF; m_axis_tready = 4'hF; exp_drops = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_tready", 32'(s_axis_tready), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("idle_tready", 32'(s_axis_tready), 32'd1);
`ifdef AXIS_DEMUX_DROP_COUNT_EN
      chk("rst_drop_count", 32'(drop_count), 32'd0);
`endif
      @(posedge clk);
      #1;

      // Three-beat packet to port 2, one-cycle latency, full throughput
      put(32'h02, 1'b0, 2, 1'b1, w);
      chk("p2_b0_valid", 32'(m_axis_tvalid), 32'b0100);
      chk("p2_b0_data", m_axis_tdata, 32'h02);
      chk("p2_b0_last", 32'(m_axis_tlast), 32'd0);
      put(32'hA1, 1'b0, 2, 1'b0, w);
      chk("p2_b1_valid", 32'(m_axis_tvalid), 32'b0100);
      chk("p2_b1_data", m_axis_tdata, 32'hA1);
      put(32'hA2, 1'b1, 2, 1'b0, w);
      chk("p2_b2_valid", 32'(m_axis_tvalid), 32'b0100);
      chk("p2_b2_data", m_axis_tdata, 32'hA2);
      chk("p2_b2_last", 32'(m_axis_tlast), 32'd1);
      @(posedge clk);
      #1;
      chk("p2_after_valid", 32'(m_axis_tvalid), 32'd0);

      // Four-beat packet to out-of-range port 7 is swallowed
      for (int i = 0; i < 4; i++) begin
         put((i == 0) ? 32'h1234_5607 : 32'hD000_0000 + 32'(i), (i == 3), 7, (i == 0), w);
         chk("drop_waits", 32'(w), 32'd0);
         chk("drop_valid", 32'(m_axis_tvalid), 32'd0);
`ifdef AXIS_DEMUX_DROP_COUNT_EN
         chk("drop_count_1", 32'(drop_count), 32'd1);
`endif
      end

      // Back-to-back packets to ports 0 and 1
      put(32'h00, 1'b0, 0, 1'b1, w); chk("b2b_w0", 32'(w), 32'd0); chk("b2b_v0", 32'(m_axis_tvalid), 32'b0001);
      put(32'h11, 1'b1, 0, 1'b0, w); chk("b2b_w1", 32'(w), 32'd0); chk("b2b_v1", 32'(m_axis_tvalid), 32'b0001);
      put(32'h01, 1'b0, 1, 1'b1, w); chk("b2b_w2", 32'(w), 32'd0); chk("b2b_v2", 32'(m_axis_tvalid), 32'b0010);
      put(32'h22, 1'b1, 1, 1'b0, w); chk("b2b_w3", 32'(w), 32'd0); chk("b2b_v3", 32'(m_axis_tvalid), 32'b0010);
      @(posedge clk);
      #1;

      // Backpressure on port 1 for five cycles
      force_ready = 4'b1101; m_axis_tready = 4'b1101;
      put(32'h01, 1'b0, 1, 1'b1, w);
      chk("bp_hdr_valid", 32'(m_axis_tvalid), 32'b0010);
      s_axis_tdata = 32'hB1; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_tready", 32'(s_axis_tready), 32'd0);
         chk("bp_valid", 32'(m_axis_tvalid), 32'b0010);
         chk("bp_data", m_axis_tdata, 32'h01);
      end
      @(posedge clk);
      #1;
      force_ready = 4'hF; m_axis_tready = 4'hF;
      wait_accept(1, 1'b0, w);
      chk("bp_resume_data", m_axis_tdata, 32'hB1);
      put(32'hB2, 1'b1, 1, 1'b0, w);
      chk("bp_tail_data", m_axis_tdata, 32'hB2);
      @(posedge clk);
      #1;

      // Reset in the middle of a packet, then the next beat is a header
      put(32'h02, 1'b0, 2, 1'b1, w);
      put(32'h55, 1'b0, 2, 1'b0, w);
      chk("mid_valid", 32'(m_axis_tvalid), 32'b0100);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(m_axis_tvalid), 32'd0);
      chk("mid_rst_tready", 32'(s_axis_tready), 32'd0);
      for (int p = 0; p < NP; p++) exp_q[p].delete();
      exp_drops = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
`ifdef AXIS_DEMUX_DROP_COUNT_EN
      chk("mid_rst_drop_count", 32'(drop_count), 32'd0);
`endif
      put(32'h03, 1'b1, 3, 1'b1, w);
      chk("post_rst_valid", 32'(m_axis_tvalid), 32'b1000);
      chk("post_rst_data", m_axis_tdata, 32'h03);

      // Randomized packets and port backpressure
      rand_ready = 1'b1;
      for (int k = 0; k < 40; k++)
         send_packet(int'($urandom_range(0, 9)), int'($urandom_range(1, 5)), 1'b1);
      rand_ready = 1'b0; force_ready = 4'hF;
      total = 1;
      for (int c = 0; c < 100 && total != 0; c++) begin
         @(posedge clk);
         #1;
         total = 0;
         for (int p = 0; p < NP; p++) total += exp_q[p].size();
      end
      chk("drain_empty", 32'(total), 32'd0);
      @(posedge clk);
      #1;
      chk("drain_valid", 32'(m_axis_tvalid), 32'd0);
`ifdef AXIS_DEMUX_DROP_COUNT_EN
      chk("rand_drop_count", 32'(drop_count), 32'(exp_drops));

      // Counter saturation
      for (int k = 0; k < 65540; k++) put(32'h0000_000F, 1'b1, 15, 1'b1, w);
      chk("sat_model", 32'(drop_count), 32'(exp_drops));
      chk("sat_drop_count", 32'(drop_count), 32'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
